// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ----------------
// Generic pipeline stage register for the pipelined MIPS CPU. It replaces the
// fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries the instruction
// word, PC+4 and a side payload across a valid/ready handshake. It also
// supports flushing and counts bubble cycles on its output.
//
// Build option:
//   SKID_BUF_EN  When defined, a second (skid) entry is compiled in and
//                in_ready comes straight from a register, so there is no
//                combinational path from out_ready to in_ready. When it is
//                undefined, the stage holds one entry and
//                in_ready = !out_valid || out_ready.
//
// Parameters:
//   DATA_W  width of the side payload
//   PC_RST  reset value of out_pc4
//   CNT_W   width of the saturating bubble counter
//
// Ports:
//   Clk         rising-edge clock
//   Reset       synchronous, active-high reset (has priority over Flush)
//   Flush       drops every held and incoming entry at the next edge
//   in_valid    upstream beat present
//   in_ready    stage accepts a beat this cycle
//   in_ir       instruction word
//   in_pc4      PC+4
//   in_data     side payload
//   out_valid   downstream beat present
//   out_ready   downstream consumes the beat this cycle
//   out_ir      instruction word; 0 (NOP) when out_valid=0
//   out_pc4     PC+4 of the current beat, or of the last valid beat
//   out_data    side payload; 0 when out_valid=0
//   bubble_cnt  saturating count of cycles with out_valid=0

module pipe_stage_reg #(
    parameter int          DATA_W = 66,
    parameter logic [31:0] PC_RST = 32'h00003000,
    parameter int          CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    input  logic [31:0]       in_pc4,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [31:0]       out_pc4,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Main entry (M). It drives every out_* port directly.
    logic              m_valid;
    logic [31:0]       m_ir;
    logic [31:0]       m_pc4;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  bub_q;

    logic accept;
    logic fire;

    assign accept = in_valid && in_ready;
    assign fire   = m_valid && out_ready;

`ifdef SKID_BUF_EN

    // Skid entry (S). It is only filled while M is held under backpressure.
    logic              s_valid;
    logic [31:0]       s_ir;
    logic [31:0]       s_pc4;
    logic [DATA_W-1:0] s_data;

    // s_valid is a flop, so in_ready is registered and does not depend on out_ready.
    assign in_ready = !s_valid;

    // M is refilled from S first, so beats keep their FIFO order. A new beat
    // goes to S only when M is full and is not firing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_valid <= 1'b0;
            m_ir    <= '0;
            m_pc4   <= PC_RST;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_ir    <= '0;
            s_pc4   <= '0;
            s_data  <= '0;
        end else if (Flush) begin
            m_valid <= 1'b0;
            m_ir    <= '0;
            m_data  <= '0;
            s_valid <= 1'b0;
        end else if (!m_valid || fire) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_ir    <= s_ir;
                m_pc4   <= s_pc4;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_ir    <= in_ir;
                m_pc4   <= in_pc4;
                m_data  <= in_data;
            end else begin
                m_valid <= 1'b0;
                m_ir    <= '0;
                m_data  <= '0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_ir    <= in_ir;
            s_pc4   <= in_pc4;
            s_data  <= in_data;
        end
    end

`else

    // A single entry can take a new beat whenever it is empty or draining this cycle.
    assign in_ready = !m_valid || out_ready;

    // Load on accept. If the entry fires and nothing replaces it, it turns
    // into a NOP bubble, and out_pc4 keeps the last valid PC+4.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_valid <= 1'b0;
            m_ir    <= '0;
            m_pc4   <= PC_RST;
            m_data  <= '0;
        end else if (Flush) begin
            m_valid <= 1'b0;
            m_ir    <= '0;
            m_data  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_ir    <= in_ir;
            m_pc4   <= in_pc4;
            m_data  <= in_data;
        end else if (fire) begin
            m_valid <= 1'b0;
            m_ir    <= '0;
            m_data  <= '0;
        end
    end

`endif

    // Bubble accounting. The counter samples out_valid before the edge,
    // saturates at all-ones, and ignores Flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bub_q <= '0;
        end else if (!m_valid && (bub_q != {CNT_W{1'b1}})) begin
            bub_q <= bub_q + CNT_W'(1);
        end
    end

    assign out_valid  = m_valid;
    assign out_ir     = m_ir;
    assign out_pc4    = m_pc4;
    assign out_data   = m_data;
    assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// -----------------
// Directed testbench for pipe_stage_reg. It drives hand-picked beats through
// the stage and compares every output against hand-computed values. A small
// bubble model tracks the expected bubble_cnt. A second instance with CNT_W=4
// exercises counter saturation. When SKID_BUF_EN is defined, the backpressure
// and flush sequences follow the two-entry behaviour.

module tb_pipe_stage_reg;

    localparam int          DATA_W = 66;
    localparam logic [31:0] PC_RST = 32'h00003000;

    logic              Clk;
    logic              Reset;
    logic              Flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_ir;
    logic [31:0]       in_pc4;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ir;
    logic [31:0]       out_pc4;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       bubble_cnt;

    logic              rst_sat;
    logic              sat_in_ready;
    logic              sat_out_valid;
    logic [31:0]       sat_out_ir;
    logic [31:0]       sat_out_pc4;
    logic [DATA_W-1:0] sat_out_data;
    logic [3:0]        sat_bub;

    int total = 0;
    int bad   = 0;
    int exp_bub = 0;
    logic cur_vld = 1'b0;

    localparam logic [31:0] IR_A = 32'h8C010004, PC_A = 32'h00003004;
    localparam logic [31:0] IR_B = 32'h00221820, PC_B = 32'h00003008;
    localparam logic [31:0] IR_C = 32'hAC030008, PC_C = 32'h0000300C;
    localparam logic [31:0] IR_D = 32'h12345678, PC_D = 32'h00003010;

    pipe_stage_reg #(.DATA_W(DATA_W), .PC_RST(PC_RST), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc4(in_pc4), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc4(out_pc4), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .PC_RST(PC_RST), .CNT_W(4)) u_sat (
        .Clk(Clk), .Reset(rst_sat), .Flush(1'b0),
        .in_valid(1'b0), .in_ready(sat_in_ready),
        .in_ir(32'h0), .in_pc4(32'h0), .in_data({DATA_W{1'b0}}),
        .out_valid(sat_out_valid), .out_ready(1'b1),
        .out_ir(sat_out_ir), .out_pc4(sat_out_pc4), .out_data(sat_out_data),
        .bubble_cnt(sat_bub)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Each beat carries a distinct payload built from its IR and PC4.
    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] ir, input logic [31:0] pc4);
        return {2'b10, ir, pc4};
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [31:0] pc4);
        in_valid = v;
        in_ir    = ir;
        in_pc4   = pc4;
        in_data  = mk_data(ir, pc4);
    endtask

    // Advance one clock edge. The bubble model uses the out_valid expected
    // before the edge, then records the out_valid expected after it.
    task automatic step(input logic vld_after);
        if (Reset) begin
            exp_bub = 0;
            cur_vld = 1'b0;
        end else begin
            if (!cur_vld && exp_bub != 65535) exp_bub++;
            cur_vld = vld_after;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] ir, input logic [31:0] pc4);
        checkOutput({tag, "_vld"}, out_valid, 1'b1);
        checkOutput({tag, "_ir"}, out_ir, ir);
        checkOutput({tag, "_pc4"}, out_pc4, pc4);
        checkOutput({tag, "_data"}, out_data, mk_data(ir, pc4));
        checkOutput({tag, "_bub"}, bubble_cnt, exp_bub);
    endtask

    task automatic checkEmpty(input string tag, input logic [31:0] pc4);
        checkOutput({tag, "_vld"}, out_valid, 1'b0);
        checkOutput({tag, "_ir"}, out_ir, 32'h0);
        checkOutput({tag, "_pc4"}, out_pc4, pc4);
        checkOutput({tag, "_data"}, out_data, {DATA_W{1'b0}});
        checkOutput({tag, "_bub"}, bubble_cnt, exp_bub);
    endtask

    initial begin
        // Reset held for two edges with no traffic
        Reset = 1'b1; rst_sat = 1'b1; Flush = 1'b0; out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(1'b0);
        step(1'b0);
        checkEmpty("rst", PC_RST);
        checkOutput("rst_bub0", bubble_cnt, 16'd0);
        checkOutput("rst_rdy", in_ready, 1'b1);
        Reset = 1'b0; rst_sat = 1'b0;
        step(1'b0);
        checkOutput("bub_1", bubble_cnt, 16'd1);
        step(1'b0);
        checkOutput("bub_2", bubble_cnt, 16'd2);

        // Three-beat stream with out_ready=1
        applyStimulus(1'b1, IR_A, PC_A); #1;
        checkOutput("str_rdy", in_ready, 1'b1);
        step(1'b1); checkBeat("strA", IR_A, PC_A);
        applyStimulus(1'b1, IR_B, PC_B);
        step(1'b1); checkBeat("strB", IR_B, PC_B);
        applyStimulus(1'b1, IR_C, PC_C);
        step(1'b1); checkBeat("strC", IR_C, PC_C);
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(1'b0); checkEmpty("strEnd", PC_C);
        checkOutput("str_bub3", bubble_cnt, 16'd3);

        // Backpressure: out_ready=0 for three edges while feeding A, B, C
        out_ready = 1'b0;
        applyStimulus(1'b1, IR_A, PC_A); #1;
        checkOutput("bp_rdy0", in_ready, 1'b1);
        step(1'b1); checkBeat("bpA0", IR_A, PC_A);
`ifdef SKID_BUF_EN
        checkOutput("bp_rdy1", in_ready, 1'b1);
        applyStimulus(1'b1, IR_B, PC_B);
        step(1'b1); checkBeat("bpA1", IR_A, PC_A);
        checkOutput("bp_rdy2", in_ready, 1'b0);
        applyStimulus(1'b1, IR_C, PC_C);
        step(1'b1); checkBeat("bpA2", IR_A, PC_A);
        checkOutput("bp_rdy3", in_ready, 1'b0);
        out_ready = 1'b1; #1;
        checkOutput("bp_rdyReg", in_ready, 1'b0);
        step(1'b1); checkBeat("bpB", IR_B, PC_B);
        checkOutput("bp_rdy4", in_ready, 1'b1);
        step(1'b1); checkBeat("bpC", IR_C, PC_C);
`else
        applyStimulus(1'b1, IR_B, PC_B); #1;
        checkOutput("bp_rdy1", in_ready, 1'b0);
        step(1'b1); checkBeat("bpA1", IR_A, PC_A);
        checkOutput("bp_rdy2", in_ready, 1'b0);
        step(1'b1); checkBeat("bpA2", IR_A, PC_A);
        out_ready = 1'b1; #1;
        checkOutput("bp_rdyComb", in_ready, 1'b1);
        step(1'b1); checkBeat("bpB", IR_B, PC_B);
        applyStimulus(1'b1, IR_C, PC_C);
        step(1'b1); checkBeat("bpC", IR_C, PC_C);
`endif
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(1'b0); checkEmpty("bpEnd", PC_C);

        // Flush while full and while a new beat is offered
        out_ready = 1'b0;
        applyStimulus(1'b1, IR_A, PC_A);
        step(1'b1); checkBeat("flA", IR_A, PC_A);
`ifdef SKID_BUF_EN
        applyStimulus(1'b1, IR_B, PC_B);
        step(1'b1); checkBeat("flA2", IR_A, PC_A);
        applyStimulus(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step(1'b1); checkBeat("flB", IR_B, PC_B);
        out_ready = 1'b0;
        applyStimulus(1'b1, IR_C, PC_C);
        step(1'b1); checkBeat("flB2", IR_B, PC_B);
        checkOutput("fl_full_rdy", in_ready, 1'b0);
        applyStimulus(1'b1, IR_D, PC_D);
        Flush = 1'b1;
        step(1'b0);
        Flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkEmpty("flush", PC_B);
        checkOutput("fl_rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        step(1'b0); checkEmpty("flAfter", PC_B);
`else
        applyStimulus(1'b1, IR_B, PC_B);
        Flush = 1'b1;
        step(1'b0);
        Flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0); #1;
        checkEmpty("flush", PC_A);
        checkOutput("fl_rdy", in_ready, 1'b1);
        out_ready = 1'b1;
        step(1'b0); checkEmpty("flAfter", PC_A);
`endif

        // Eight-beat burst: fire and accept on every edge
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h20000000 + 32'(i), 32'h00004000 + 32'(4 * i)); #1;
            checkOutput("burst_rdy", in_ready, 1'b1);
            step(1'b1);
            checkBeat("burst", 32'h20000000 + 32'(i), 32'h00004000 + 32'(4 * i));
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        step(1'b0); checkEmpty("burstEnd", 32'h0000401C);

        // Saturation of a 4-bit counter, then reset clears it
        rst_sat = 1'b1;
        step(1'b0); step(1'b0);
        checkOutput("sat_rst", sat_bub, 4'd0);
        rst_sat = 1'b0;
        repeat (14) step(1'b0);
        checkOutput("sat_14", sat_bub, 4'd14);
        repeat (6) step(1'b0);
        checkOutput("sat_15", sat_bub, 4'd15);
        rst_sat = 1'b1;
        step(1'b0);
        checkOutput("sat_clr", sat_bub, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
